// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared BCD definitions: FSM state encodings and the largest legal decimal digit.
// Also intended for reuse by the counter-side modules.
package bcd_to_bin_seq_pkg;

  typedef enum logic {
    STATE_IDLE = 1'b0,
    STATE_CONV = 1'b1
  } state_e;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_to_bin_seq_mul10_add.sv
// Combinational acc*10 + nib step for the BCD converter, built from shifts and adds.
// Also flags a nibble that is not a decimal digit.
module mul10_add
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int W = 14
) (
  input  logic [W-1:0] acc,
  input  logic [3:0]   nib,
  output logic [W-1:0] sum,
  output logic         nib_invalid
);

  // Overflow wraps silently; it only happens for invalid input, whose result is discarded.
  always_comb begin
    sum         = (acc << 3) + (acc << 1) + W'(nib);
    nib_invalid = (nib > BCD_MAX_DIGIT);
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter, one digit per clock, MSD first,
// with a start/busy/done handshake and a flag for non-decimal nibbles.
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int NDIGITS  = 4,
  parameter int BINWIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NDIGITS*4-1:0]  BCD,
  output logic                  busy,
  output logic                  done,
  output logic [BINWIDTH-1:0]   bin,
  output logic                  err
);

  localparam int CNTW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NDIGITS - 1);

  state_e                state, state_nxt;
  logic [NDIGITS*4-1:0]  sreg;
  logic [BINWIDTH-1:0]   acc;
  logic [BINWIDTH-1:0]   acc_nxt;
  logic [CNTW-1:0]       cnt;
  logic                  err_acc;
  logic [3:0]            nib;
  logic                  nib_invalid;
  logic                  accept;
  logic                  step;
  logic                  finish;

  function automatic logic [BINWIDTH-1:0] force_zero_on_err(
    input logic [BINWIDTH-1:0] value,
    input logic                bad
  );
    return bad ? '0 : value;
  endfunction

  assign nib = sreg[NDIGITS*4-1 -: 4];

  mul10_add #(.W(BINWIDTH)) u_mul10_add (
    .acc         (acc),
    .nib         (nib),
    .sum         (acc_nxt),
    .nib_invalid (nib_invalid)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= STATE_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      STATE_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = STATE_CONV;
        end
      end
      STATE_CONV: begin
        step = 1'b1;
        if (cnt == LAST_CNT) begin
          finish    = 1'b1;
          state_nxt = STATE_IDLE;
        end
      end
      default: state_nxt = STATE_IDLE;
    endcase
  end

  assign busy = (state == STATE_CONV);

  // Digit datapath and result registers; reset clears everything so a
  // mid-conversion reset leaves no stale result behind.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sreg    <= '0;
      acc     <= '0;
      cnt     <= '0;
      err_acc <= 1'b0;
      bin     <= '0;
      err     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        sreg    <= BCD;
        acc     <= '0;
        cnt     <= '0;
        err_acc <= 1'b0;
      end else if (step) begin
        sreg    <= sreg << 4;
        acc     <= acc_nxt;
        cnt     <= cnt + 1'b1;
        err_acc <= err_acc | nib_invalid;
        if (finish) begin
          bin <= force_zero_on_err(acc_nxt, err_acc | nib_invalid);
          err <= err_acc | nib_invalid;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Testbench for bcd_to_bin_seq: vector table, handshake corner cases,
// full 0000-9999 sweep and random patterns against an integer reference.
module tb_bcd_to_bin_seq;

  localparam int NDIGITS  = 4;
  localparam int BINWIDTH = 14;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic [NDIGITS*4-1:0] BCD = '0;
  logic                 busy;
  logic                 done;
  logic [BINWIDTH-1:0]  bin;
  logic                 err;

  int total = 0;
  int bad   = 0;

  bcd_to_bin_seq #(.NDIGITS(NDIGITS), .BINWIDTH(BINWIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .BCD   (BCD),
    .busy  (busy),
    .done  (done),
    .bin   (bin),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    int          exp_bin;
    bit          exp_err;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: decimal digits read MSD first with plain integer arithmetic.
  function automatic void ref_conv(input logic [15:0] b, output int val, output bit e);
    val = 0;
    e   = 1'b0;
    for (int k = NDIGITS - 1; k >= 0; k--) begin
      int d;
      d = int'((b >> (4 * k)) & 16'hF);
      if (d > 9) e = 1'b1;
      val = val * 10 + d;
    end
    if (e) val = 0;
  endfunction

  // Pulses start for one cycle, then waits for done; reports edges to done and busy cycles.
  task automatic convert(input logic [15:0] b, output int rbin, output bit rerr,
                         output int edges, output int busy_cycles);
    BCD   = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    BCD   = 16'hFFFF;
    edges = 1;
    busy_cycles = 0;
    while (!done && edges < 12) begin
      if (busy) busy_cycles++;
      tick();
      edges++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL timeout: no done for bcd %h after %0d edges", b, edges);
    end
    rbin = int'(bin);
    rerr = err;
  endtask

  vec_t vecs[10];

  initial begin
    int rb, ed, bc, eb, pulses, first_pulse, last_pulse, gap_bad;
    bit re, ee;
    int digits[NDIGITS];
    logic [15:0] bv;

    if ((2.0 ** BINWIDTH) <= (10.0 ** NDIGITS) - 1.0) begin
      $display("FAIL param: BINWIDTH %0d too small for %0d digits", BINWIDTH, NDIGITS);
      $fatal(1, "bad parameters");
    end

    vecs[0] = '{16'h1234, 1234, 1'b0};
    vecs[1] = '{16'h9999, 9999, 1'b0};
    vecs[2] = '{16'h0000, 0,    1'b0};
    vecs[3] = '{16'h12A4, 0,    1'b1};
    vecs[4] = '{16'h0042, 42,   1'b0};
    vecs[5] = '{16'h0007, 7,    1'b0};
    vecs[6] = '{16'hF000, 0,    1'b1};
    vecs[7] = '{16'h9000, 9000, 1'b0};
    vecs[8] = '{16'h000B, 0,    1'b1};
    vecs[9] = '{16'h1009, 1009, 1'b0};

    // Reset then idle
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("idle_outputs", int'({busy, done, err, bin}), 0);
      tick();
    end

    // Vector table
    foreach (vecs[i]) begin
      convert(vecs[i].bcd, rb, re, ed, bc);
      check($sformatf("vec%0d_bin", i), rb, vecs[i].exp_bin);
      check($sformatf("vec%0d_err", i), int'(re), int'(vecs[i].exp_err));
      check($sformatf("vec%0d_latency", i), ed, NDIGITS + 1);
      check($sformatf("vec%0d_busy", i), bc, NDIGITS);
    end
    tick();
    check("done_single_pulse", int'(done), 0);
    check("bin_held", int'(bin), 1009);

    // start during busy is ignored
    BCD = 16'h1234; start = 1'b1; tick();
    start = 1'b0; tick();
    BCD = 16'h5555; start = 1'b1; tick();
    start = 1'b0;
    ed = 0;
    while (!done && ed < 12) begin tick(); ed++; end
    check("busy_start_done_seen", int'(done), 1);
    check("busy_start_bin", int'(bin), 1234);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) pulses++;
    end
    check("busy_start_no_queue", pulses, 0);

    // start held high: done every NDIGITS+1 cycles
    BCD = 16'h0007; start = 1'b1;
    pulses = 0; first_pulse = -1; last_pulse = -1; gap_bad = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (done) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
        else if (i - last_pulse != NDIGITS + 1) gap_bad++;
        last_pulse = i;
        check("held_bin", int'(bin), 7);
      end
    end
    start = 1'b0;
    check("held_pulses", pulses, 3);
    check("held_first", first_pulse, NDIGITS + 1);
    check("held_gap", gap_bad, 0);
    repeat (6) tick();

    // Reset mid-conversion
    BCD = 16'h8888; start = 1'b1; tick();
    start = 1'b0; tick(); tick();
    rst = 1'b0; tick();
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_bin", int'(bin), 0);
    check("midrst_err", int'(err), 0);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) pulses++;
      tick();
    end
    check("midrst_no_done", pulses, 0);
    convert(16'h0042, rb, re, ed, bc);
    check("after_rst_bin", rb, 42);
    check("after_rst_err", int'(re), 0);

    // Sweep driven by a bench-side decimal counter
    for (int k = 0; k < NDIGITS; k++) digits[k] = 0;
    for (int v = 0; v < 10000; v++) begin
      bv = '0;
      for (int k = 0; k < NDIGITS; k++) bv[4*k +: 4] = 4'(digits[k]);
      convert(bv, rb, re, ed, bc);
      if (rb != v || re != 1'b0) check($sformatf("sweep_%0d", v), rb + (int'(re) << 20), v);
      else total++;
      for (int k = 0; k < NDIGITS; k++) begin
        if (digits[k] == 9) digits[k] = 0;
        else begin digits[k]++; break; end
      end
    end

    // Random patterns, including non-decimal nibbles
    for (int n = 0; n < 300; n++) begin
      bv = 16'($urandom);
      ref_conv(bv, eb, ee);
      convert(bv, rb, re, ed, bc);
      check($sformatf("rand_bin_%h", bv), rb, eb);
      check($sformatf("rand_err_%h", bv), int'(re), int'(ee));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
